// File: rtl/fetch_unit.sv
// fetch_unit -- front-end instruction fetch stage.
//
// Owns the architectural PC. Issues one instruction-memory read at a time,
// and hands {insn, pc} to decode through a one-entry valid/ready buffer.
// A redirect from branch resolution replaces the PC. The redirect also
// squashes the buffered instruction and any fetch still in flight.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   redirectValid   new PC supplied this cycle (highest priority)
//   redirectPC      new PC; low log2(PC_INC) bits are forced to zero
//   imemReqValid    read request valid (combinational)
//   imemReqReady    memory accepts the request
//   imemReqAddr     read address (= pc)
//   imemRespValid   read data returned, at least one cycle after acceptance
//   imemRespData    instruction word
//   outValid        output buffer holds an instruction
//   outReady        decode consumes when outValid && outReady
//   outInsn, outPC  buffered instruction and its PC
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPC,
  output logic                  imemReqValid,
  input  logic                  imemReqReady,
  output logic [ADDR_WIDTH-1:0] imemReqAddr,
  input  logic                  imemRespValid,
  input  logic [INSN_WIDTH-1:0] imemRespData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [INSN_WIDTH-1:0] outInsn,
  output logic [ADDR_WIDTH-1:0] outPC
);

  localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(PC_INC);
  // PC_INC is a power of two, so INC-1 covers exactly the always-zero PC bits.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(INC - ADDR_WIDTH'(1));

  typedef enum logic {S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic [INSN_WIDTH-1:0] insn;
    logic [ADDR_WIDTH-1:0] pc;
  } fetchOut_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflightPC;
  logic                  drop;     // the outstanding response belongs to a squashed fetch
  fetchOut_t             outBuf;

  logic outFire;
  logic reqFire;

  // Issue only while the buffer is empty or draining this cycle. The buffer is
  // therefore guaranteed free when the single outstanding response returns.
  assign imemReqValid = (state == S_REQ) && !drop && !redirectValid &&
                        (!outValid || outReady);
  assign imemReqAddr  = pc;
  assign reqFire      = imemReqValid && imemReqReady;
  assign outFire      = outValid && outReady;

  assign outInsn = outBuf.insn;
  assign outPC   = outBuf.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      inflightPC <= '0;
      drop       <= 1'b0;
      outValid   <= 1'b0;
      outBuf     <= '0;
    end else if (redirectValid) begin
      // A redirect overrides everything, including a decode handshake this cycle.
      pc       <= redirectPC & ALIGN_MASK;
      outValid <= 1'b0;
      if (state == S_WAIT) begin
        if (imemRespValid) begin
          // The stale response arrives with the redirect. Discard it here,
          // so there is nothing left to drop.
          drop  <= 1'b0;
          state <= S_REQ;
        end else begin
          drop <= 1'b1;
        end
      end
    end else begin
      if (outFire) outValid <= 1'b0;

      case (state)
        S_REQ: begin
          // A response in REQ is a protocol violation and is ignored.
          if (reqFire) begin
            inflightPC <= pc;
            pc         <= pc + INC;   // wraps silently
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imemRespValid) begin
            if (drop) begin
              drop <= 1'b0;
            end else begin
              // The load overrides the clear above when decode drains in the same cycle.
              outValid    <= 1'b1;
              outBuf.insn <= imemRespData;
              outBuf.pc   <= inflightPC;
            end
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. A cycle table drives the main instance and states
// the expected outputs for each cycle. A scoreboard queue holds the expected
// decode deliveries, and a second instance covers RESET_PC wrap-around.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst = 1'b1, redirectValid = 1'b0, imemReqReady = 1'b0;
  logic        imemRespValid = 1'b0, outReady = 1'b0;
  logic [31:0] redirectPC = '0, imemRespData = '0;
  logic        imemReqValid, outValid;
  logic [31:0] imemReqAddr, outInsn, outPC;

  fetch_unit u0 (
    .clk(clk), .rst(rst), .redirectValid(redirectValid), .redirectPC(redirectPC),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .outValid(outValid), .outReady(outReady), .outInsn(outInsn), .outPC(outPC)
  );

  // wrap-around instance
  logic        bRst = 1'b1, bRv = 1'b0, bRdy = 1'b0, bRespV = 1'b0, bORdy = 1'b0;
  logic [31:0] bRpc = '0, bRespD = '0;
  logic        bReqV, bOV;
  logic [31:0] bAddr, bInsn, bPC;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(4)) u1 (
    .clk(clk), .rst(bRst), .redirectValid(bRv), .redirectPC(bRpc),
    .imemReqValid(bReqV), .imemReqReady(bRdy), .imemReqAddr(bAddr),
    .imemRespValid(bRespV), .imemRespData(bRespD),
    .outValid(bOV), .outReady(bORdy), .outInsn(bInsn), .outPC(bPC)
  );

  int passCnt = 0;
  int checkCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard of expected decode deliveries {insn, pc}
  logic [63:0] sbq[$];

  task automatic push(input logic [31:0] insn, input logic [31:0] pc);
    sbq.push_back({insn, pc});
  endtask

  // Called away from the clock edge. A handshake that is not squashed takes the next expected item.
  task automatic scoreHandshake(input string tag);
    logic [63:0] e;
    if (outValid && outReady && !redirectValid && !rst) begin
      if (sbq.size() == 0) begin
        check({tag, " unexpected delivery"}, {outInsn, outPC}, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        e = sbq.pop_front();
        check({tag, " delivery"}, {outInsn, outPC}, e);
      end
    end
  endtask

  typedef struct {
    logic        r, rv;
    logic [31:0] rpc;
    logic        rdy, respV;
    logic [31:0] d;
    logic        oRdy;
    logic        dlv;      // this response should reach decode
    logic [31:0] dpc;
    logic        eReqV;
    logic [31:0] eAddr;
    logic        eOV;
    logic [31:0] eInsn, ePC;
  } vec_t;

  function automatic vec_t V(logic r, logic rv, logic [31:0] rpc, logic rdy, logic respV,
                             logic [31:0] d, logic oRdy, logic dlv, logic [31:0] dpc,
                             logic eReqV, logic [31:0] eAddr, logic eOV,
                             logic [31:0] eInsn, logic [31:0] ePC);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.respV = respV; v.d = d;
    v.oRdy = oRdy; v.dlv = dlv; v.dpc = dpc; v.eReqV = eReqV; v.eAddr = eAddr;
    v.eOV = eOV; v.eInsn = eInsn; v.ePC = ePC;
    return v;
  endfunction

  localparam int NV = 32;
  vec_t tbl[NV];

  initial begin
    //          r rv rpc     rdy rsp d      ordy dlv dpc | reqV addr    oV insn   pc
    tbl[0]  = V(1,0, 0,      0, 0, 0,       1, 0, 0,      1, 0,       0, 0,     0);
    tbl[1]  = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 0,       0, 0,     0);
    tbl[2]  = V(0,0, 0,      1, 1, 0,       1, 1, 0,      0, 4,       0, 0,     0);
    tbl[3]  = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 4,       1, 0,     0);
    tbl[4]  = V(0,0, 0,      1, 1, 1,       1, 1, 4,      0, 8,       0, 0,     0);
    tbl[5]  = V(0,0, 0,      1, 0, 0,       0, 0, 0,      0, 8,       1, 1,     4);
    tbl[6]  = V(0,0, 0,      1, 0, 0,       0, 0, 0,      0, 8,       1, 1,     4);
    tbl[7]  = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 8,       1, 1,     4);
    tbl[8]  = V(0,0, 0,      1, 1, 2,       1, 1, 8,      0, 12,      0, 0,     0);
    tbl[9]  = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 12,      1, 2,     8);
    tbl[10] = V(0,1, 'h100,  0, 0, 0,       1, 0, 0,      0, 16,      0, 0,     0);
    tbl[11] = V(0,0, 0,      0, 0, 0,       1, 0, 0,      0, 'h100,   0, 0,     0);
    tbl[12] = V(0,0, 0,      0, 0, 0,       1, 0, 0,      0, 'h100,   0, 0,     0);
    tbl[13] = V(0,0, 0,      0, 1, 3,       1, 0, 0,      0, 'h100,   0, 0,     0);
    tbl[14] = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 'h100,   0, 0,     0);
    tbl[15] = V(0,0, 0,      0, 1, 'h40,    1, 0, 0,      0, 'h104,   0, 0,     0);
    tbl[16] = V(0,0, 0,      1, 0, 0,       0, 0, 0,      0, 'h104,   1, 'h40,  'h100);
    tbl[17] = V(0,1, 'h200,  1, 1, 'h99,    1, 0, 0,      0, 'h104,   1, 'h40,  'h100);
    tbl[18] = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 'h200,   0, 0,     0);
    tbl[19] = V(0,1, 'h300,  0, 1, 'h77,    1, 0, 0,      0, 'h204,   0, 0,     0);
    tbl[20] = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 'h300,   0, 0,     0);
    tbl[21] = V(0,0, 0,      0, 1, 'hC0,    1, 0, 0,      0, 'h304,   0, 0,     0);
    tbl[22] = V(0,1, 'h103,  0, 0, 0,       1, 0, 0,      0, 'h304,   1, 'hC0,  'h300);
    tbl[23] = V(0,0, 0,      0, 0, 0,       1, 0, 0,      1, 'h100,   0, 0,     0);
    tbl[24] = V(0,0, 0,      0, 0, 0,       1, 0, 0,      1, 'h100,   0, 0,     0);
    tbl[25] = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 'h100,   0, 0,     0);
    tbl[26] = V(0,1, 'h500,  0, 0, 0,       1, 0, 0,      0, 'h104,   0, 0,     0);
    tbl[27] = V(0,1, 'h600,  0, 0, 0,       1, 0, 0,      0, 'h500,   0, 0,     0);
    tbl[28] = V(0,0, 0,      0, 1, 'hEE,    1, 0, 0,      0, 'h600,   0, 0,     0);
    tbl[29] = V(0,0, 0,      1, 0, 0,       1, 0, 0,      1, 'h600,   0, 0,     0);
    tbl[30] = V(0,0, 0,      0, 1, 'h55,    1, 0, 0,      0, 'h604,   0, 0,     0);
    tbl[31] = V(0,0, 0,      1, 0, 0,       0, 0, 0,      0, 'h604,   1, 'h55,  'h600);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].r; redirectValid = tbl[i].rv; redirectPC = tbl[i].rpc;
      imemReqReady = tbl[i].rdy; imemRespValid = tbl[i].respV;
      imemRespData = tbl[i].d; outReady = tbl[i].oRdy;
      if (tbl[i].dlv) push(tbl[i].d, tbl[i].dpc);
      #1;
      check($sformatf("r%0d reqValid", i), 64'(imemReqValid), 64'(tbl[i].eReqV));
      check($sformatf("r%0d reqAddr", i), 64'(imemReqAddr), 64'(tbl[i].eAddr));
      check($sformatf("r%0d outValid", i), 64'(outValid), 64'(tbl[i].eOV));
      if (tbl[i].eOV) begin
        check($sformatf("r%0d outInsn", i), 64'(outInsn), 64'(tbl[i].eInsn));
        check($sformatf("r%0d outPC", i), 64'(outPC), 64'(tbl[i].ePC));
      end
      scoreHandshake($sformatf("r%0d", i));
    end

    // The buffer is full here. Assert the async reset between edges.
    @(negedge clk);
    imemReqReady = 1'b0; outReady = 1'b0; imemRespValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst outValid", 64'(outValid), 64'(0));
    check("async rst reqAddr", 64'(imemReqAddr), 64'(0));

    @(negedge clk);
    rst = 1'b0; imemReqReady = 1'b1; outReady = 1'b1;
    #1;
    check("post-rst reqValid", 64'(imemReqValid), 64'(1));
    check("post-rst reqAddr", 64'(imemReqAddr), 64'(0));
    scoreHandshake("post-rst");

    // Now in WAIT for address 0. Reset again mid-WAIT.
    @(negedge clk);
    imemReqReady = 1'b0;
    #1;
    check("wait reqValid", 64'(imemReqValid), 64'(0));
    check("wait reqAddr", 64'(imemReqAddr), 64'(4));
    #2 rst = 1'b1;
    #1;
    check("rst-in-wait reqValid", 64'(imemReqValid), 64'(1));
    check("rst-in-wait reqAddr", 64'(imemReqAddr), 64'(0));

    @(negedge clk);
    rst = 1'b0; imemReqReady = 1'b1;
    #1;
    check("rerelease reqAddr", 64'(imemReqAddr), 64'(0));
    check("rerelease reqValid", 64'(imemReqValid), 64'(1));
    @(negedge clk);
    imemReqReady = 1'b0; imemRespValid = 1'b1; imemRespData = 32'h11;
    push(32'h11, 32'h0);
    #1 scoreHandshake("rerelease resp");
    @(negedge clk);
    imemRespValid = 1'b0;
    #1 scoreHandshake("rerelease drain");
    check("scoreboard empty", 64'(sbq.size()), 64'(0));

    // RESET_PC wrap-around and redirect alignment on the second instance
    @(negedge clk);
    bRst = 1'b0; bRdy = 1'b1; bORdy = 1'b1;
    #1;
    check("wrap reqValid0", 64'(bReqV), 64'(1));
    check("wrap addr0", 64'(bAddr), 64'hFFFF_FFFC);
    @(negedge clk);
    bRdy = 1'b0; bRespV = 1'b1; bRespD = 32'hAB;
    #1;
    check("wrap addr1", 64'(bAddr), 64'h0);
    check("wrap wait reqValid", 64'(bReqV), 64'(0));
    @(negedge clk);
    bRespV = 1'b0; bRdy = 1'b1;
    #1;
    check("wrap outPC", 64'(bPC), 64'hFFFF_FFFC);
    check("wrap outInsn", 64'(bInsn), 64'hAB);
    check("wrap next reqValid", 64'(bReqV), 64'(1));
    check("wrap next addr", 64'(bAddr), 64'h0);
    @(negedge clk);
    bRdy = 1'b0; bRv = 1'b1; bRpc = 32'h103;
    @(negedge clk);
    bRv = 1'b0; bRespV = 1'b1; bRespD = 32'h0;
    @(negedge clk);
    bRespV = 1'b0; bRdy = 1'b1;
    #1;
    check("aligned redirect reqValid", 64'(bReqV), 64'(1));
    check("aligned redirect addr", 64'(bAddr), 64'h100);
    check("squashed delivery outValid", 64'(bOV), 64'(0));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
